// File: rtl/fpu_host_ctrl.sv
// Byte-serial host front end for the 23-bit FPU: operand load,
// op issue with idle watchdog, result capture and readback.
module fpu_host_ctrl #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        fpu_add,
  output logic        fpu_sub,
  output logic        fpu_mul,
  output logic        reg1_s,
  output logic [6:0]  reg1_e,
  output logic [14:0] reg1_m,
  output logic        reg2_s,
  output logic [6:0]  reg2_e,
  output logic [14:0] reg2_m,
  input  logic        res_s,
  input  logic [6:0]  res_e,
  input  logic [14:0] res_m,
  input  logic        zero_flag,
  input  logic        overflow_flag,
  input  logic        underflow_flag,
  input  logic        fpu_idle,
  output logic        busy
);

  localparam logic [5:0]  TMO      = 6'(TIMEOUT);
  localparam logic [22:0] ZERO_ENC = 23'h204000;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WLAT,
    S_WDONE, S_CAPT, S_SEND
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic        lat_q, lat_d;
  logic [5:0]  wdog_q, wdog_d;
  logic        live_q, selb_q;
  logic [15:0] sh_q;
  logic [22:0] a_q, b_q, r_q;
  logic        add_q, sub_q, mul_q;
  logic        err_q, tmo_q;
  logic        zf_q, of_q, uf_q;

  logic [3:0]  op;
  logic        hs_in, hs_out, go;
  logic        dec_ld, dec_ex, dec_rd;
  logic        dec_mv, dec_bad;
  logic [22:0] ld_val;
  logic        unused_bits;

  assign op          = in_data[7:4];
  assign unused_bits = in_data[0];
  assign in_ready    = live_q &
    (state_q == S_IDLE || state_q == S_LOAD);
  assign out_valid   = (state_q == S_SEND);
  assign busy        = (state_q != S_IDLE);
  assign hs_in       = in_valid & in_ready;
  assign hs_out      = out_valid & out_ready;
  assign go          = (state_q == S_IDLE) & hs_in;
  assign ld_val      = {sh_q, in_data[7:1]};

  assign fpu_add = add_q;
  assign fpu_sub = sub_q;
  assign fpu_mul = mul_q;
  assign {reg1_s, reg1_e, reg1_m} = a_q;
  assign {reg2_s, reg2_e, reg2_m} = b_q;

  always_comb begin
    dec_ld  = 1'b0;
    dec_ex  = 1'b0;
    dec_rd  = 1'b0;
    dec_mv  = 1'b0;
    dec_bad = 1'b0;
    unique case (1'b1)
      (op == 4'h1), (op == 4'h2): dec_ld = 1'b1;
      (op == 4'h3), (op == 4'h4),
      (op == 4'h5):               dec_ex = 1'b1;
      (op == 4'h6):               dec_rd = 1'b1;
      (op == 4'h7):               dec_mv = 1'b1;
      default:                    dec_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    lat_d   = lat_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs_in && dec_ld) begin
          state_d = S_LOAD;
          bcnt_d  = 2'd0;
        end else if (hs_in && dec_ex) begin
          state_d = S_ISSUE;
        end else if (hs_in && dec_rd) begin
          state_d = S_SEND;
          bcnt_d  = 2'd0;
        end
      end
      S_LOAD: begin
        if (hs_in) begin
          if (bcnt_q == 2'd2) state_d = S_IDLE;
          else bcnt_d = bcnt_q + 2'd1;
        end
      end
      S_ISSUE: begin
        state_d = S_WLAT;
        lat_d   = 1'b0;
      end
      // fpu_idle is stale until the FPU has left idle
      S_WLAT: begin
        lat_d = 1'b1;
        if (lat_q) begin
          state_d = S_WDONE;
          wdog_d  = 6'd0;
        end
      end
      S_WDONE: begin
        if (fpu_idle) state_d = S_CAPT;
        else if (wdog_q == TMO) state_d = S_IDLE;
        else wdog_d = wdog_q + 6'd1;
      end
      S_CAPT: state_d = S_IDLE;
      S_SEND: begin
        if (hs_out) begin
          if (bcnt_q == 2'd3) state_d = S_IDLE;
          else bcnt_d = bcnt_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_data = 8'h00;
    if (out_valid) begin
      unique case (bcnt_q)
        2'd0: out_data = {1'b0, err_q, tmo_q, 2'b00,
                          zf_q, of_q, uf_q};
        2'd1: out_data = r_q[22:15];
        2'd2: out_data = r_q[14:7];
        2'd3: out_data = {r_q[6:0], 1'b0};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= 2'd0;
      lat_q   <= 1'b0;
      wdog_q  <= 6'd0;
      live_q  <= 1'b0;
      selb_q  <= 1'b0;
      sh_q    <= 16'h0;
      a_q     <= ZERO_ENC;
      b_q     <= ZERO_ENC;
      r_q     <= ZERO_ENC;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
      mul_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      lat_q   <= lat_d;
      wdog_q  <= wdog_d;
      live_q  <= 1'b1;
      add_q   <= go & (op == 4'h3);
      sub_q   <= go & (op == 4'h4);
      mul_q   <= go & (op == 4'h5);
      if (go && dec_ld) selb_q <= op[1];
      if (go && dec_mv) a_q <= r_q;
      if (go && dec_bad) err_q <= 1'b1;
      // operands commit whole, never byte by byte
      if (state_q == S_LOAD && hs_in) begin
        case (bcnt_q)
          2'd0:    sh_q[15:8] <= in_data;
          2'd1:    sh_q[7:0]  <= in_data;
          default: begin
            if (selb_q) b_q <= ld_val;
            else a_q <= ld_val;
          end
        endcase
      end
      if (state_q == S_WDONE && !fpu_idle && wdog_q == TMO)
        tmo_q <= 1'b1;
      if (state_q == S_CAPT) begin
        r_q  <= {res_s, res_e, res_m};
        zf_q <= zero_flag;
        of_q <= overflow_flag;
        uf_q <= underflow_flag;
      end
      if (hs_out && bcnt_q == 2'd0) begin
        err_q <= 1'b0;
        tmo_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_host_ctrl.sv
// Bench for fpu_host_ctrl: load table, FPU stub with latency/hang,
// directed corner sequences and a randomized command stream.
module tb_fpu_host_ctrl;

  localparam int TMO = 63;
  localparam logic [22:0] ZENC = 23'h204000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        fpu_add, fpu_sub, fpu_mul;
  logic        reg1_s, reg2_s;
  logic [6:0]  reg1_e, reg2_e;
  logic [14:0] reg1_m, reg2_m;
  logic        res_s;
  logic [6:0]  res_e;
  logic [14:0] res_m;
  logic        zero_flag, overflow_flag;
  logic        underflow_flag, fpu_idle;
  logic        busy;

  fpu_host_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready),
    .fpu_add(fpu_add), .fpu_sub(fpu_sub),
    .fpu_mul(fpu_mul),
    .reg1_s(reg1_s), .reg1_e(reg1_e),
    .reg1_m(reg1_m),
    .reg2_s(reg2_s), .reg2_e(reg2_e),
    .reg2_m(reg2_m),
    .res_s(res_s), .res_e(res_e), .res_m(res_m),
    .zero_flag(zero_flag),
    .overflow_flag(overflow_flag),
    .underflow_flag(underflow_flag),
    .fpu_idle(fpu_idle), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // FPU behaviour shared by stub and model: returns {z,o,u,res}
  function automatic logic [25:0] fpu_fn(
    input int k, input logic [22:0] a,
    input logic [22:0] b);
    logic [22:0] r;
    logic [45:0] p;
    p = a * b;
    case (k)
      0:       r = a + b;
      1:       r = a - b;
      default: r = p[22:0] ^ p[45:23];
    endcase
    return {(r[14:0] == 15'h0), r[22], r[0], r};
  endfunction

  int stub_lat = 8;
  bit hang = 1'b0;
  int scnt;

  always @(posedge clk) begin
    if (reset) begin
      fpu_idle       <= 1'b1;
      scnt           <= 0;
      res_s          <= 1'b0;
      res_e          <= 7'h0;
      res_m          <= 15'h0;
      zero_flag      <= 1'b0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else if (fpu_add | fpu_sub | fpu_mul) begin
      {zero_flag, overflow_flag, underflow_flag,
       res_s, res_e, res_m} <= fpu_fn(
        fpu_add ? 0 : (fpu_sub ? 1 : 2),
        {reg1_s, reg1_e, reg1_m},
        {reg2_s, reg2_e, reg2_m});
      fpu_idle <= 1'b0;
      scnt     <= stub_lat;
    end else if (!hang && scnt > 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) fpu_idle <= 1'b1;
    end
  end

  int n_add = 0, n_sub = 0, n_mul = 0, n_multi = 0;

  always @(posedge clk) begin
    if (fpu_add) n_add++;
    if (fpu_sub) n_sub++;
    if (fpu_mul) n_mul++;
    if (int'(fpu_add) + int'(fpu_sub)
        + int'(fpu_mul) > 1) n_multi++;
  end

  logic [22:0] mA, mB, mR;
  bit mErr, mTmo, mZ, mO, mU;

  task automatic model_reset();
    mA = ZENC; mB = ZENC; mR = ZENC;
    mErr = 0; mTmo = 0; mZ = 0; mO = 0; mU = 0;
  endtask

  function automatic logic [22:0] port_a();
    return {reg1_s, reg1_e, reg1_m};
  endfunction

  function automatic logic [22:0] port_b();
    return {reg2_s, reg2_e, reg2_m};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 500) begin
        chk("idle_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic read_resp(input bit stall,
                           output logic [31:0] got);
    int n, cnt;
    bit held, hold_ok, rdy_ok;
    logic [7:0] hd;
    n = 0; cnt = 0; held = 0; hd = 0;
    hold_ok = 1; rdy_ok = 1; got = 0;
    while (cnt < 4 && n < 200) begin
      @(negedge clk);
      n++;
      out_ready = stall ? n[0] : 1'b1;
      if (held && out_data !== hd) hold_ok = 0;
      if (out_valid && in_ready) rdy_ok = 0;
      if (out_valid && out_ready) begin
        got = {got[23:0], out_data};
        cnt++;
        held = 0;
      end else if (out_valid) begin
        held = 1;
        hd   = out_data;
      end
    end
    chk("read_len", cnt, 4);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("read_end", {out_valid, in_ready}, 2'b01);
    if (stall) begin
      chk("read_hold", hold_ok, 1);
      chk("read_inrdy", rdy_ok, 1);
    end
  endtask

  task automatic do_read(input string name,
                         input bit stall);
    logic [31:0] got, exp;
    exp = {1'b0, mErr, mTmo, 2'b00, mZ, mO, mU,
           mR[22:15], mR[14:7], mR[6:0], 1'b0};
    send_byte({4'h6, 4'($urandom)});
    read_resp(stall, got);
    chk(name, got, exp);
    mErr = 0;
    mTmo = 0;
  endtask

  task automatic do_load(input bit selb,
                         input logic [7:0] b0,
                         input logic [7:0] b1,
                         input logic [7:0] b2,
                         input logic [22:0] exp);
    logic [22:0] oa, ob;
    oa = port_a();
    ob = port_b();
    send_byte({selb ? 4'h2 : 4'h1, 4'($urandom)});
    send_byte(b0);
    send_byte(b1);
    chk("load_hold", {port_a(), port_b()}, {oa, ob});
    chk("load_busy", busy, 1);
    send_byte(b2);
    if (selb) begin
      chk("load_b", {port_a(), port_b()}, {oa, exp});
      mB = exp;
    end else begin
      chk("load_a", {port_a(), port_b()}, {exp, ob});
      mA = exp;
    end
  endtask

  task automatic do_exec(input int k);
    int da, ds, dm, n;
    da = n_add; ds = n_sub; dm = n_mul;
    send_byte({4'(3 + k), 4'($urandom)});
    wait_idle(n);
    chk("strobe",
        {8'(n_add - da), 8'(n_sub - ds), 8'(n_mul - dm)},
        {8'(k == 0), 8'(k == 1), 8'(k == 2)});
    if (hang) begin
      mTmo = 1;
      chk("tmo_len", (n >= TMO + 3 && n <= TMO + 5), 1);
    end else begin
      {mZ, mO, mU, mR} = fpu_fn(k, mA, mB);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_outs"},
        {in_ready, out_valid, out_data, fpu_add,
         fpu_sub, fpu_mul, busy}, 0);
    chk({name, "_regs"}, {port_a(), port_b()},
        {ZENC, ZENC});
  endtask

  typedef struct {
    bit          selb;
    logic [7:0]  b0, b1, b2;
    logic [22:0] exp;
  } ld_vec_t;

  ld_vec_t lv[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int da, ds, dm, k, j;
    logic [7:0] b0, b1, b2;

    lv[0] = '{0, 8'h00, 8'h80, 8'h00, 23'h004000};
    lv[1] = '{1, 8'h01, 8'h80, 8'h00, 23'h00C000};
    lv[2] = '{0, 8'hFF, 8'hFF, 8'hFF, 23'h7FFFFF};
    lv[3] = '{1, 8'h81, 8'h23, 8'h45, 23'h4091A2};
    lv[4] = '{0, 8'h40, 8'h80, 8'h00, 23'h204000};
    lv[5] = '{1, 8'h3C, 8'h5A, 8'h01, 23'h1E2D00};

    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b0;
    chk("rdy_low_at_deassert", in_ready, 0);
    @(negedge clk);
    chk("rdy_rise", {in_ready, busy}, 2'b10);

    for (int i = 0; i < 6; i++)
      do_load(lv[i].selb, lv[i].b0, lv[i].b1,
              lv[i].b2, lv[i].exp);

    // 1.0 + 2.0 with an 8-cycle FPU
    stub_lat = 8;
    do_load(0, 8'h00, 8'h80, 8'h00, 23'h004000);
    do_load(1, 8'h01, 8'h80, 8'h00, 23'h00C000);
    do_exec(0);
    do_read("read_add", 0);

    hang = 1'b1;
    do_exec(2);
    hang = 1'b0;
    do_read("read_tmo", 0);
    do_read("read_tmo_clr", 0);

    da = n_add; ds = n_sub; dm = n_mul;
    send_byte(8'hA0);
    mErr = 1;
    repeat (6) @(negedge clk);
    chk("bad_nostrobe",
        (n_add - da) + (n_sub - ds) + (n_mul - dm), 0);
    chk("bad_idle", busy, 0);
    do_read("read_err", 0);
    do_read("read_err_clr", 0);

    do_read("read_stall", 1);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 7);
      case (k)
        0, 1: begin
          b0 = 8'($urandom);
          b1 = 8'($urandom);
          b2 = 8'($urandom);
          do_load(k[0], b0, b1, b2, {b0, b1, b2[7:1]});
        end
        2: begin
          stub_lat = $urandom_range(2, 12);
          do_exec($urandom_range(0, 2));
        end
        3: do_read("rnd_read", $urandom_range(0, 1) == 1);
        4: begin
          send_byte({4'h7, 4'($urandom)});
          mA = mR;
          chk("move", port_a(), mA);
        end
        5: begin
          j = $urandom_range(0, 8);
          da = n_add; ds = n_sub; dm = n_mul;
          send_byte({(j == 0) ? 4'h0 : 4'(7 + j),
                     4'($urandom)});
          mErr = 1;
          repeat (5) @(negedge clk);
          chk("rnd_bad",
              (n_add - da) + (n_sub - ds) + (n_mul - dm),
              0);
        end
        default: begin
          stub_lat = $urandom_range(2, 12);
          do_exec($urandom_range(0, 2));
          do_read("rnd_exec_read", 0);
        end
      endcase
    end

    // reset while polling the FPU
    hang = 1'b1;
    send_byte(8'h30);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst_wdone");
    da = n_add; ds = n_sub; dm = n_mul;
    reset = 1'b0;
    hang  = 1'b0;
    model_reset();
    chk("rst_wdone_rdy0", in_ready, 0);
    repeat (100) @(negedge clk);
    chk("rst_wdone_nostrobe",
        (n_add - da) + (n_sub - ds) + (n_mul - dm), 0);
    chk("rst_wdone_idle", {in_ready, busy}, 2'b10);

    // reset in the middle of an operand load
    do_load(0, 8'hFF, 8'hFF, 8'hFF, 23'h7FFFFF);
    do_load(1, 8'h81, 8'h23, 8'h45, 23'h4091A2);
    send_byte(8'h10);
    send_byte(8'h55);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst_load");
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_load_regs", {port_a(), port_b()},
        {ZENC, ZENC});
    do_read("read_after_rst", 0);

    chk("strobe_excl", n_multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_host_ctrl.md
# fpu_host_ctrl

Byte-serial host controller in front of the 23-bit FPU. It assembles operands A and B from an 8-bit command stream and drives them onto the FPU operand ports. It issues add/sub/mul strobes and tracks the FPU idle handshake with a watchdog. It captures the result and flags, and streams them back out on an 8-bit valid/ready port.

## Interface
- Parameters:
  - TIMEOUT, default 63: max cycles in WAIT_DONE before abort (6-bit counter).
- Ports:
  - clk  in  1  clock
  - reset  in  1  reset, synchronous, active-high
  - in_valid  in  1  command/data byte valid
  - in_data  in  8  command/data byte
  - in_ready  out  1  byte accepted when in_valid & in_ready
  - out_valid  out  1  response byte valid
  - out_data  out  8  response byte
  - out_ready  in  1  host accepts response byte
  - fpu_add / fpu_sub / fpu_mul  out  1 each  one-cycle registered op strobes
  - reg1_s, reg1_e[6:0], reg1_m[14:0]  out  operand A (registered)
  - reg2_s, reg2_e[6:0], reg2_m[14:0]  out  operand B (registered)
  - res_s, res_e[6:0], res_m[14:0]  in  FPU result
  - zero_flag, overflow_flag, underflow_flag, fpu_idle  in  FPU status
  - busy  out  1  high in any state except IDLE

## Operation
- Float packing, 3 bytes, MSB first:
  - byte0 = {s, e[6:0]}
  - byte1 = m[14:7]
  - byte2 = {m[6:0], 1'b0}; bit0 is ignored on load.
- Opcodes are taken from in_data[7:4]; in_data[3:0] is ignored.
  - 0x1 LOAD_A: next 3 bytes go to A.
  - 0x2 LOAD_B: next 3 bytes go to B.
  - 0x3 ADD, 0x4 SUB, 0x5 MUL: execute.
  - 0x6 READ: emit status byte, then 3 RES bytes.
  - 0x7 MOVE: RES -> A, one cycle.
  - Any other opcode: ignored; sets sticky err.
- Status byte = {1'b0, err, tmo, 2'b00, zero, ovf, unf}. Reading status clears err and tmo. zero/ovf/unf persist until the next capture.
- States:
  - IDLE: in_ready = 1. Opcode decode. LOAD_x -> LOAD, with byte counter bcnt = 0. Execute -> ISSUE. READ -> SEND. MOVE and illegal opcodes stay in IDLE.
  - LOAD: in_ready = 1. Each accepted byte is written into a shadow register at bcnt. After bcnt = 2, the whole 23 bits are committed to the A/B output registers in one cycle, then -> IDLE. The operand ports never show a partial value.
  - ISSUE: the selected strobe is high for exactly this cycle -> WAIT_LAT.
  - WAIT_LAT: 2 cycles; fpu_idle is ignored because it is stale until the FPU has left IDLE -> WAIT_DONE.
  - WAIT_DONE: wdog increments each cycle. fpu_idle = 1 -> CAPTURE. wdog = TIMEOUT -> set tmo, RES unchanged -> IDLE.
  - CAPTURE: RES <= {res_s, res_e, res_m}; zero/ovf/unf latched -> IDLE.
  - SEND: out_valid = 1. out_data is selected by bcnt (0 = status, 1..3 = RES bytes). bcnt advances only on out_valid & out_ready. After the bcnt = 3 transfer -> IDLE.
- in_ready = 0 in ISSUE, WAIT_LAT, WAIT_DONE, CAPTURE and SEND. Bytes offered there are held off, not dropped.
- A, B and RES reset to the FPU zero encoding: s = 0, e = 7'h40, m = 15'h4000 (bytes 0x40, 0x80, 0x00).

## Timing
- Reset values:
  - Outputs: in_ready = 0, out_valid = 0, out_data = 0, all strobes = 0, busy = 0.
  - reg1_*/reg2_* = zero encoding.
  - err = tmo = zero = ovf = unf = 0; state = IDLE.
  - in_ready rises the cycle after reset deasserts.
- Reset mid-operation (any state) aborts immediately; no strobe is emitted after reset.
- LOAD latency: the A/B ports change on the cycle after the 3rd byte handshake.
- Execute latency: op byte accepted at edge T.
  - Strobe is high during cycle T+1.
  - WAIT_LAT covers T+2..T+3.
  - Polling starts at T+4.
  - RES updates one cycle after fpu_idle is sampled high.
- Back-to-back: a new opcode is accepted on the first IDLE cycle after CAPTURE, LOAD or SEND.
- SEND holds out_data stable while out_valid & !out_ready.
- Strobes are mutually exclusive; at most one strobe per execute command.

## Test plan
- LOAD_A 0x10, 0x00, 0x80, 0x00 -> reg1_e = 0, reg1_m = 0x4000, reg1_s = 0. The ports change only after byte 3; busy is high during LOAD.
- Bench FPU stub with 8-cycle latency: LOAD A = 1.0, LOAD B = 2.0 (0x01, 0x80, 0x00), then ADD 0x30 -> fpu_add high exactly 1 cycle. READ 0x60 -> 4 bytes: status, then the stub's res packed, e.g. res e = 2, m = 0x6000 -> 0x02, 0xC0, 0x00.
- Stub keeps fpu_idle low forever, then MUL 0x50 -> after TIMEOUT cycles returns to IDLE. READ status = 0x20 and RES is unchanged. A second READ gives status 0x00.
- Illegal opcode 0xA0 -> no strobe. READ status = 0x40. A subsequent READ gives status 0x00.
- READ with out_ready toggling 1/0 each cycle -> exactly 4 bytes in order, each held while stalled. in_ready stays 0 until the last byte.
- Assert reset during WAIT_DONE and during LOAD bcnt = 1 -> all outputs return to reset values, reg1/reg2 = 0x40/0x80/0x00 encoding, and no strobe appears afterwards.
